// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, data width and default baud divisor.
// The same divisor default is used by the transmitter so that a TX/RX pair matches out of the box.
package uart_pkg;

  localparam int UART_DATA_BITS            = 8;
  localparam int UART_CLKS_PER_BIT_DEFAULT = 217;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    START      = 3'd1,
    DATA       = 3'd2,
    STOP       = 3'd3,
    BREAK_WAIT = 3'd4
  } uart_rx_state_e;

endpackage

// File: rtl/sync_ff_chain.sv
// Multi-flop synchroniser for asynchronous inputs; STAGES cycles of latency, resets to all-ones.
// No backpressure: samples every clock.
module sync_ff_chain #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             i_Rst_L,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q;

  // Reset to ones so an idle-high line never looks like an edge after reset.
  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver; byte strobe lands at the stop-bit centre, about (SYNC_STAGES+1)+HALF+9*CLKS_PER_BIT+1 cycles after the start edge.
// No backpressure: o_RX_DV / o_RX_Frame_Err are single-cycle strobes and o_RX_Byte holds the last good byte.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT_DEFAULT,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                      clk,
  input  logic                      i_Rst_L,
  input  logic                      i_RX_Serial,
  output logic                      o_RX_DV,
  output logic [UART_DATA_BITS-1:0] o_RX_Byte,
  output logic                      o_RX_Frame_Err,
  output logic                      o_RX_Active
);

  localparam int            CW     = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF_C = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] LAST_C = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

  logic                      rx_s;
  uart_rx_state_e            state_q;
  logic [CW-1:0]             clk_cnt_q;
  logic [2:0]                bit_idx_q;
  logic [UART_DATA_BITS-1:0] shift_q;

  sync_ff_chain #(
    .WIDTH  (1),
    .STAGES (SYNC_STAGES)
  ) u_rx_sync (
    .clk     (clk),
    .i_Rst_L (i_Rst_L),
    .d_i     (i_RX_Serial),
    .q_o     (rx_s)
  );

  always_ff @(posedge clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q        <= IDLE;
      clk_cnt_q      <= '0;
      bit_idx_q      <= '0;
      shift_q        <= '0;
      o_RX_DV        <= 1'b0;
      o_RX_Byte      <= '0;
      o_RX_Frame_Err <= 1'b0;
      o_RX_Active    <= 1'b0;
    end else begin
      o_RX_DV        <= 1'b0;
      o_RX_Frame_Err <= 1'b0;
      case (state_q)
        IDLE: begin
          clk_cnt_q <= '0;
          bit_idx_q <= '0;
          if (!rx_s) begin
            state_q     <= START;
            o_RX_Active <= 1'b1;
          end
        end
        // Re-check the line half a bit in; a short low pulse is discarded silently.
        START: begin
          if (clk_cnt_q == HALF_C) begin
            clk_cnt_q <= '0;
            if (!rx_s) begin
              state_q <= DATA;
            end else begin
              state_q     <= IDLE;
              o_RX_Active <= 1'b0;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        DATA: begin
          if (clk_cnt_q == LAST_C) begin
            clk_cnt_q          <= '0;
            shift_q[bit_idx_q] <= rx_s;
            if (bit_idx_q == LAST_BIT) begin
              bit_idx_q <= '0;
              state_q   <= STOP;
            end else begin
              bit_idx_q <= bit_idx_q + 3'd1;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        // Leave at the stop-bit centre so a start bit straight after it is not missed.
        STOP: begin
          if (clk_cnt_q == LAST_C) begin
            clk_cnt_q   <= '0;
            o_RX_Active <= 1'b0;
            if (rx_s) begin
              o_RX_Byte <= shift_q;
              o_RX_DV   <= 1'b1;
              state_q   <= IDLE;
            end else begin
              o_RX_Frame_Err <= 1'b1;
              state_q        <= BREAK_WAIT;
            end
          end else begin
            clk_cnt_q <= clk_cnt_q + CW'(1);
          end
        end
        // A held-low (break) line must return high before a new start is accepted.
        BREAK_WAIT: begin
          clk_cnt_q <= '0;
          if (rx_s) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q     <= IDLE;
          clk_cnt_q   <= '0;
          bit_idx_q   <= '0;
          o_RX_Active <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed + randomized checks of uart_rx_core against a frame-level serial model.
module tb_uart_rx_core;

  localparam int C     = 8;
  localparam int SYNC  = 2;
  localparam int HALF  = (C - 1) / 2;
  localparam int LAT   = (SYNC + 1) + HALF + 9 * C + 1;

  logic       clk;
  logic       i_Rst_L;
  logic       i_RX_Serial;
  logic       o_RX_DV;
  logic [7:0] o_RX_Byte;
  logic       o_RX_Frame_Err;
  logic       o_RX_Active;

  uart_rx_core #(
    .CLKS_PER_BIT (C),
    .SYNC_STAGES  (SYNC)
  ) dut (
    .clk            (clk),
    .i_Rst_L        (i_Rst_L),
    .i_RX_Serial    (i_RX_Serial),
    .o_RX_DV        (o_RX_DV),
    .o_RX_Byte      (o_RX_Byte),
    .o_RX_Frame_Err (o_RX_Frame_Err),
    .o_RX_Active    (o_RX_Active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: collects strobes at negedge and flags strobe-rule violations.
  logic [7:0] rx_q[$];
  int         dv_cyc_q[$];
  int         fe_cnt     = 0;
  int         strobe_bad = 0;
  bit         act_seen   = 0;
  bit         prev_strobe = 0;

  always @(negedge clk) begin
    if (o_RX_DV) begin
      rx_q.push_back(o_RX_Byte);
      dv_cyc_q.push_back(cyc);
    end
    if (o_RX_Frame_Err) fe_cnt++;
    if (o_RX_DV && o_RX_Frame_Err) strobe_bad++;
    if ((o_RX_DV || o_RX_Frame_Err) && prev_strobe) strobe_bad++;
    prev_strobe = o_RX_DV || o_RX_Frame_Err;
    if (o_RX_Active) act_seen = 1'b1;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] rx_at(input int i);
    if (i < rx_q.size()) return rx_q[i];
    return 8'hxx;
  endfunction

  function automatic int dv_at(input int i);
    if (i < dv_cyc_q.size()) return dv_cyc_q[i];
    return -100000;
  endfunction

  function automatic logic in_win(input int v, input int target);
    return (v >= target - 1) && (v <= target + 1);
  endfunction

  task automatic clear_mon();
    rx_q.delete();
    dv_cyc_q.delete();
    fe_cnt   = 0;
    act_seen = 0;
  endtask

  // Called and returns at posedge+1.
  task automatic drive(input logic v, input int n);
    i_RX_Serial = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Serial model of an 8N1 transmitter: start, 8 data bits LSB first, stop.
  task automatic send_frame(input logic [7:0] d, input logic stop_bit, output int fall_cyc);
    fall_cyc = cyc;
    drive(1'b0, C);
    for (int i = 0; i < 8; i++) drive(d[i], C);
    drive(stop_bit, C);
  endtask

  int         f0, f1, lat;
  logic [7:0] rnd;
  logic [7:0] exp_q[$];

  initial begin
    i_Rst_L     = 1'b0;
    i_RX_Serial = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_dv",     o_RX_DV,        0);
    chk("rst_byte",   o_RX_Byte,      0);
    chk("rst_fe",     o_RX_Frame_Err, 0);
    chk("rst_active", o_RX_Active,    0);
    @(posedge clk); #1;
    i_Rst_L = 1'b1;
    drive(1'b1, 4);

    // 1: clean frame and strobe latency
    clear_mon();
    send_frame(8'hA5, 1'b1, f0);
    drive(1'b1, 2 * C);
    chk("t1_count", rx_q.size(), 1);
    chk("t1_byte",  rx_at(0), 8'hA5);
    chk("t1_fe",    fe_cnt, 0);
    lat = dv_at(0) - f0;
    chk("t1_latency_in_window", in_win(lat, LAT), 1);
    chk("t1_active_low", o_RX_Active, 0);

    // 2: short glitch is rejected, next frame still received
    clear_mon();
    drive(1'b0, 2);
    drive(1'b1, 2 * C);
    chk("t2_count",       rx_q.size(), 0);
    chk("t2_fe",          fe_cnt, 0);
    chk("t2_active_seen", act_seen, 1);
    chk("t2_active_low",  o_RX_Active, 0);
    send_frame(8'h3C, 1'b1, f0);
    drive(1'b1, 2 * C);
    chk("t2_next_count", rx_q.size(), 1);
    chk("t2_next_byte",  rx_at(0), 8'h3C);

    // 3: framing error followed by a held-low break
    clear_mon();
    send_frame(8'h5A, 1'b0, f0);
    drive(1'b0, 40);
    chk("t3_fe_count",    fe_cnt, 1);
    chk("t3_dv_count",    rx_q.size(), 0);
    chk("t3_byte_held",   o_RX_Byte, 8'h3C);
    chk("t3_break_idle",  o_RX_Active, 0);
    drive(1'b1, C);
    send_frame(8'h81, 1'b1, f0);
    drive(1'b1, 2 * C);
    chk("t3_next_count", rx_q.size(), 1);
    chk("t3_next_byte",  rx_at(0), 8'h81);
    chk("t3_fe_total",   fe_cnt, 1);

    // 4: back-to-back frames with a single stop bit
    clear_mon();
    send_frame(8'h00, 1'b1, f0);
    send_frame(8'hFF, 1'b1, f1);
    drive(1'b1, 2 * C);
    chk("t4_count", rx_q.size(), 2);
    chk("t4_byte0", rx_at(0), 8'h00);
    chk("t4_byte1", rx_at(1), 8'hFF);
    chk("t4_spacing_in_window", in_win(dv_at(1) - dv_at(0), 10 * C), 1);

    // 5: reset in the middle of data bit 4
    clear_mon();
    f0 = cyc;
    drive(1'b0, C);
    for (int i = 0; i < 4; i++) drive(1'b1, C);
    drive(1'b0, C / 2);
    chk("t5_active_before", o_RX_Active, 1);
    i_Rst_L = 1'b0;
    #1;
    chk("t5_rst_dv",     o_RX_DV,        0);
    chk("t5_rst_byte",   o_RX_Byte,      0);
    chk("t5_rst_fe",     o_RX_Frame_Err, 0);
    chk("t5_rst_active", o_RX_Active,    0);
    i_RX_Serial = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_Rst_L = 1'b1;
    drive(1'b1, 12 * C);
    chk("t5_no_dv", rx_q.size(), 0);
    chk("t5_no_fe", fe_cnt, 0);
    send_frame(8'hC3, 1'b1, f0);
    drive(1'b1, 2 * C);
    chk("t5_next_count", rx_q.size(), 1);
    chk("t5_next_byte",  rx_at(0), 8'hC3);

    // 6: random byte stream, modelled transmitter, random idle gaps
    clear_mon();
    exp_q.delete();
    for (int k = 0; k < 16; k++) begin
      rnd = 8'($urandom);
      exp_q.push_back(rnd);
      send_frame(rnd, 1'b1, f0);
      drive(1'b1, int'($urandom_range(0, 5)));
    end
    drive(1'b1, 2 * C);
    chk("t6_count", rx_q.size(), 16);
    chk("t6_fe",    fe_cnt, 0);
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("t6_byte%0d", k), rx_at(k), exp_q[k]);
    end

    chk("strobe_rules", strobe_bad, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
